// File: rtl/load_store_unit_if.sv
// Execute-stage request, completion status and data-memory bus of the load/store unit.
// master: the load/store unit itself; slave: the core/memory side driving it.
interface load_store_unit_if;
  logic        req_valid;
  logic [2:0]  mem_read_type;
  logic [3:0]  mem_write_mask;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_err;
  logic        dmem_valid;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    input  req_valid, mem_read_type, mem_write_mask, addr, store_data,
    input  dmem_ready, dmem_rvalid, dmem_rdata,
    output stall, done, load_data, misalign, bus_err,
    output dmem_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
  );

  modport slave (
    output req_valid, mem_read_type, mem_write_mask, addr, store_data,
    output dmem_ready, dmem_rvalid, dmem_rdata,
    input  stall, done, load_data, misalign, bus_err,
    input  dmem_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// One load/store at a time over a valid/ready data bus; latency 2 cycles min (store), loads wait for rvalid.
// Stalls the core while the bus is busy; bounded by TIMEOUT_CYCLES, ends with a one-cycle done pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  load_store_unit_if.master io_lsu
);
  localparam logic [2:0] RD_BYTE = 3'd1;
  localparam logic [2:0] RD_HALF = 3'd2;
  localparam logic [2:0] RD_WORD = 3'd3;
  localparam logic [2:0] RD_BU   = 3'd4;
  localparam logic [2:0] RD_HU   = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_is_read;
  logic [2:0]  r_rd_type;
  logic [1:0]  r_off;
  logic [29:0] r_word;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt;
  logic [31:0] r_load_data;
  logic        r_misalign;
  logic        r_bus_err;

  logic        w_rd_act, w_wr_act, w_act, w_misal, w_tmo;
  logic        w_accept, w_err, w_cap;
  logic [1:0]  w_size;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Decode the incoming request; a read code takes priority over a write mask.
  always_comb begin
    w_rd_act = io_lsu.mem_read_type inside {RD_BYTE, RD_HALF, RD_WORD, RD_BU, RD_HU};
    w_wr_act = |io_lsu.mem_write_mask;
    w_act    = w_rd_act || w_wr_act;
    if (w_rd_act) begin
      case (io_lsu.mem_read_type)
        RD_HALF, RD_HU: w_size = 2'd1;
        RD_WORD:        w_size = 2'd2;
        default:        w_size = 2'd0;
      endcase
    end else begin
      w_size = io_lsu.mem_write_mask[3] ? 2'd2 : (io_lsu.mem_write_mask[1] ? 2'd1 : 2'd0);
    end
    w_misal = ((w_size == 2'd1) && io_lsu.addr[0]) || ((w_size == 2'd2) && (|io_lsu.addr[1:0]));
    w_wstrb = io_lsu.mem_write_mask << io_lsu.addr[1:0];
    case (w_size)
      2'd0:    w_wdata = {4{io_lsu.store_data[7:0]}};
      2'd1:    w_wdata = {2{io_lsu.store_data[15:0]}};
      default: w_wdata = io_lsu.store_data;
    endcase
  end

  always_comb begin
    w_byte = io_lsu.dmem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? io_lsu.dmem_rdata[31:16] : io_lsu.dmem_rdata[15:0];
    case (r_rd_type)
      RD_BYTE: w_ext = {{24{w_byte[7]}}, w_byte};
      RD_BU:   w_ext = {24'd0, w_byte};
      RD_HALF: w_ext = {{16{w_half[15]}}, w_half};
      RD_HU:   w_ext = {16'd0, w_half};
      default: w_ext = io_lsu.dmem_rdata;
    endcase
  end

  // r_cnt equals the number of cycles already spent in REQ/WAIT_R.
  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // A completing handshake or response in the last budgeted cycle beats the timeout.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_err    = 1'b0;
    w_cap    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_lsu.req_valid && w_act) begin
          w_accept = 1'b1;
          w_next   = w_misal ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (io_lsu.dmem_ready && !r_is_read) begin
          w_next = S_DONE;
        end else if (w_tmo) begin
          w_next = S_DONE;
          w_err  = 1'b1;
        end else if (io_lsu.dmem_ready) begin
          w_next = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (io_lsu.dmem_rvalid) begin
          w_next = S_DONE;
          w_cap  = 1'b1;
        end else if (w_tmo) begin
          w_next = S_DONE;
          w_err  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_is_read   <= 1'b0;
      r_rd_type   <= 3'd0;
      r_off       <= 2'd0;
      r_word      <= 30'd0;
      r_wstrb     <= 4'd0;
      r_wdata     <= 32'd0;
      r_cnt       <= 32'd0;
      r_load_data <= 32'd0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_read   <= w_rd_act;
        r_rd_type   <= io_lsu.mem_read_type;
        r_off       <= io_lsu.addr[1:0];
        r_word      <= io_lsu.addr[31:2];
        r_wstrb     <= w_wstrb;
        r_wdata     <= w_wdata;
        r_cnt       <= 32'd0;
        r_load_data <= 32'd0;
        r_misalign  <= w_misal;
        r_bus_err   <= 1'b0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT_R)) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_err) r_bus_err   <= 1'b1;
      if (w_cap) r_load_data <= w_ext;
    end
  end

  assign io_lsu.stall      = (r_state == S_IDLE) ? (io_lsu.req_valid && w_act)
                                                 : ((r_state == S_REQ) || (r_state == S_WAIT_R));
  assign io_lsu.done       = (r_state == S_DONE);
  assign io_lsu.load_data  = r_load_data;
  assign io_lsu.misalign   = r_misalign;
  assign io_lsu.bus_err    = r_bus_err;
  assign io_lsu.dmem_valid = (r_state == S_REQ);
  assign io_lsu.dmem_we    = (r_state == S_REQ) && !r_is_read;
  assign io_lsu.dmem_addr  = (r_state == S_REQ) ? {r_word, 2'b00} : 32'd0;
  assign io_lsu.dmem_wstrb = ((r_state == S_REQ) && !r_is_read) ? r_wstrb : 4'd0;
  assign io_lsu.dmem_wdata = ((r_state == S_REQ) && !r_is_read) ? r_wdata : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized load/store traffic against an arithmetic reference model; a scoreboard
// queue holds the expected completion of each request and a monitor checks every done pulse.
module tb_load_store_unit;
  localparam int T     = 16;
  localparam int NEVER = 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if lsu();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_lsu  (lsu.master)
  );

  typedef struct {
    logic        mis;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int size_of(input logic [2:0] rt, input logic [3:0] mask);
    if (rt >= 3'd1 && rt <= 3'd5) return (rt == 3'd3) ? 4 : ((rt == 3'd2 || rt == 3'd5) ? 2 : 1);
    if (mask == 4'hF) return 4;
    if (mask == 4'h3) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] rt, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] bv, hv;
    bv = (rd >> (8 * a[1:0])) & 32'hFF;
    hv = (rd >> (16 * a[1])) & 32'hFFFF;
    case (rt)
      3'd1:    return (bv >= 128) ? bv + 32'hFFFFFF00 : bv;
      3'd4:    return bv;
      3'd2:    return (hv >= 32768) ? hv + 32'hFFFF0000 : hv;
      3'd5:    return hv;
      default: return rd;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (lsu.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("misalign", lsu.misalign, e.mis);
        chk("bus_err", lsu.bus_err, e.err);
        chk("stall_at_done", lsu.stall, 1'b0);
        if (e.chk_data) chk("load_data", lsu.load_data, e.data);
      end
    end
  end

  task automatic txn(input logic [2:0] rt, input logic [3:0] mask, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd, input int d1, input int d2);
    bit   is_rd, act, mis, ok, got_done;
    int   sz, exp_idx, last_evt, stop;
    exp_t e;
    is_rd = (rt >= 3'd1 && rt <= 3'd5);
    act   = is_rd || (mask != 4'h0);
    sz    = size_of(rt, mask);
    mis   = act && ((a % sz) != 0);
    ok    = is_rd ? (d1 + 1 + d2 <= T - 1) : (d1 <= T - 1);
    @(negedge clk);
    lsu.req_valid      = 1'b1;
    lsu.mem_read_type  = rt;
    lsu.mem_write_mask = mask;
    lsu.addr           = a;
    lsu.store_data     = sd;
    lsu.dmem_rdata     = rd;
    #1 chk("stall_idle", lsu.stall, act);
    if (!act) begin
      @(negedge clk);
      lsu.req_valid = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("inactive_no_bus", lsu.dmem_valid, 1'b0);
      end
      return;
    end
    e.mis      = mis;
    e.err      = !mis && !ok;
    e.chk_data = !mis && ok && is_rd;
    e.data     = ref_load(rt, a, rd);
    exp_q.push_back(e);
    exp_idx  = mis ? 0 : (!ok ? T : (is_rd ? d1 + 2 + d2 : d1 + 1));
    last_evt = is_rd ? d1 + 1 + d2 : d1;
    stop     = (last_evt + 1 < T + 10) ? last_evt + 1 : T + 10;
    got_done = 1'b0;
    for (int idx = 0; idx < T + 12; idx++) begin
      @(negedge clk);
      lsu.req_valid = 1'b0;
      if (!got_done && lsu.done === 1'b1) begin
        got_done = 1'b1;
        chk("done_latency", idx, exp_idx);
        chk("no_bus_at_done", lsu.dmem_valid, 1'b0);
      end else if (!got_done) begin
        chk("stall_busy", lsu.stall, 1'b1);
        if (!mis && idx <= d1 && idx < T) begin
          chk("dmem_valid", lsu.dmem_valid, 1'b1);
          chk("dmem_addr", lsu.dmem_addr, a & 32'hFFFFFFFC);
          chk("dmem_we", lsu.dmem_we, !is_rd);
          if (!is_rd) begin
            chk("dmem_wstrb", lsu.dmem_wstrb, (mask << a[1:0]) & 4'hF);
            chk("dmem_wdata", lsu.dmem_wdata,
                (sz == 1) ? sd[7:0] * 32'h01010101 : ((sz == 2) ? sd[15:0] * 32'h00010001 : sd));
          end
        end else begin
          chk("dmem_valid_low", lsu.dmem_valid, 1'b0);
        end
      end
      lsu.dmem_ready  = (idx == d1);
      lsu.dmem_rvalid = is_rd && (idx == d1 + 1 + d2);
      if (got_done && idx >= stop) break;
    end
    lsu.dmem_ready  = 1'b0;
    lsu.dmem_rvalid = 1'b0;
    if (!got_done) begin
      chk("done_never_seen", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rt;
    logic [3:0]  mask;
    logic [31:0] a;
    int          d1, d2, r;
    rst_n = 1'b0;
    lsu.req_valid = 1'b0; lsu.mem_read_type = 3'd0; lsu.mem_write_mask = 4'd0;
    lsu.addr = 32'd0; lsu.store_data = 32'd0;
    lsu.dmem_ready = 1'b0; lsu.dmem_rvalid = 1'b0; lsu.dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_stall", lsu.stall, 1'b0);
    chk("rst_done", lsu.done, 1'b0);
    chk("rst_dmem_valid", lsu.dmem_valid, 1'b0);
    chk("rst_load_data", lsu.load_data, 32'd0);
    chk("rst_flags", {lsu.misalign, lsu.bus_err}, 2'b00);
    rst_n = 1'b1;

    txn(3'd1, 4'h0, 32'h1003, 32'h0, 32'h80112233, 0, 0);     // lb
    txn(3'd4, 4'h0, 32'h1003, 32'h0, 32'h80112233, 0, 0);     // lbu
    txn(3'd0, 4'h3, 32'h102, 32'h1234ABCD, 32'h0, 0, 0);      // sh
    txn(3'd3, 4'h0, 32'h101, 32'h0, 32'h0, 0, 0);             // lw misaligned
    txn(3'd0, 4'hF, 32'h200, 32'hDEADBEEF, 32'h0, 3, 0);      // sw, ready late
    txn(3'd2, 4'h0, 32'h300, 32'h0, 32'h0, 0, NEVER);         // lh timeout
    txn(3'd0, 4'h1, 32'h400, 32'h5A, 32'h0, NEVER, 0);        // sb, never ready
    txn(3'd3, 4'hF, 32'h500, 32'h0, 32'hCAFEF00D, 1, 1);      // read wins over write
    txn(3'd0, 4'h0, 32'h600, 32'h0, 32'h0, 0, 0);             // inactive

    // Reset while waiting for read data; the late response must be ignored.
    @(negedge clk);
    lsu.req_valid = 1'b1; lsu.mem_read_type = 3'd3; lsu.mem_write_mask = 4'h0;
    lsu.addr = 32'h700; lsu.dmem_rdata = 32'h13572468;
    @(negedge clk);
    lsu.req_valid = 1'b0; lsu.dmem_ready = 1'b1;
    @(negedge clk);
    lsu.dmem_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; lsu.dmem_rvalid = 1'b1;
    chk("midrst_dmem_valid", lsu.dmem_valid, 1'b0);
    chk("midrst_stall", lsu.stall, 1'b0);
    chk("midrst_flags", {lsu.done, lsu.misalign, lsu.bus_err}, 3'b000);
    @(negedge clk);
    lsu.dmem_rvalid = 1'b0;
    chk("midrst_late_rvalid_done", lsu.done, 1'b0);
    chk("midrst_load_data", lsu.load_data, 32'd0);
    txn(3'd3, 4'h0, 32'h704, 32'h0, 32'h2468ACE0, 0, 1);

    for (int i = 0; i < 150; i++) begin
      rt = 3'd0; mask = 4'h0;
      if ($urandom_range(0, 1) == 1) rt = 3'($urandom_range(0, 5));
      else mask = (i % 3 == 0) ? 4'h1 : ((i % 3 == 1) ? 4'h3 : 4'hF);
      if ($urandom_range(0, 9) == 0) begin rt = 3'($urandom_range(1, 5)); mask = 4'hF; end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(rt, mask)) - 32'd1);
      r  = $urandom_range(0, 9);
      d1 = (r == 0) ? NEVER : ((r < 3) ? $urandom_range(12, 17) : $urandom_range(0, 4));
      r  = $urandom_range(0, 9);
      d2 = (r == 0) ? NEVER : ((r < 3) ? $urandom_range(10, 17) : $urandom_range(0, 4));
      txn(rt, mask, a, $urandom, $urandom, d1, d2);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
